// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_scoreboard_pkg
//  Brief   : Opcode/function encodings and select-width helper for the
//            decode-stage hazard scoreboard.
//  Rev     : 1.0  initial release
// ============================================================================
package hazard_scoreboard_pkg;

    localparam logic [5:0] c_OP_R    = 6'h00;
    localparam logic [5:0] c_OP_JMP  = 6'h02;
    localparam logic [5:0] c_OP_BEQ  = 6'h04;
    localparam logic [5:0] c_OP_BNE  = 6'h05;
    localparam logic [5:0] c_OP_ADDI = 6'h08;
    localparam logic [5:0] c_OP_LUI  = 6'h0F;
    localparam logic [5:0] c_OP_LW   = 6'h23;
    localparam logic [5:0] c_OP_SW   = 6'h2B;

    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_SRA  = 6'h03;

    localparam int c_REG_FIELD_W = 5;

    // Forward select must encode 0 (regfile) plus stages 1..depth.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic is_itype_alu(input logic [5:0] op);
        return op inside {[c_OP_ADDI:c_OP_LUI]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_scoreboard_if
//  Brief   : ID-stage request and hazard response bundle.
//  Rev     : 1.0  initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
);
    import hazard_scoreboard_pkg::*;

    localparam int SEL_W = sel_width(DEPTH);

    logic [31:0]      id_instr;
    logic             id_valid;
    logic             hold;
    logic             flush;
    logic             stall;
    logic [SEL_W-1:0] fwd_rs;
    logic [SEL_W-1:0] fwd_rt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_instr, id_valid, hold, flush,
        input  stall, fwd_rs, fwd_rt, stall_cnt
    );

    modport slave (
        input  id_instr, id_valid, hold, flush,
        output stall, fwd_rs, fwd_rt, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_reg_usage_decode.sv
`default_nettype none
// ============================================================================
//  Module  : reg_usage_decode
//  Brief   : Extracts source operands read and destination written by an
//            instruction, plus whether it is a load.
//  Rev     : 1.0  initial release
// ============================================================================
module reg_usage_decode
    import hazard_scoreboard_pkg::*;
(
    input  wire  [31:0]               i_instr,
    output logic [c_REG_FIELD_W-1:0]  o_rs,
    output logic                      o_read_rs,
    output logic [c_REG_FIELD_W-1:0]  o_rt,
    output logic                      o_read_rt,
    output logic [c_REG_FIELD_W-1:0]  o_dst,
    output logic                      o_dst_valid,
    output logic                      o_is_load
);
    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_has_dst;
    logic       w_unused_shamt;

    assign w_op           = i_instr[31:26];
    assign w_fn           = i_instr[5:0];
    assign o_rs           = i_instr[25:21];
    assign o_rt           = i_instr[20:16];
    assign w_unused_shamt = ^i_instr[10:6];
    assign o_is_load      = (w_op == c_OP_LW);

    always_comb begin
        o_read_rs = 1'b1;
        o_read_rt = 1'b0;
        o_dst     = '0;
        w_has_dst = 1'b0;
        if (w_op == c_OP_R) begin
            // Shift-immediate forms take the source in rt; the rs field is unused.
            o_read_rs = !(w_fn inside {c_FN_SLL, c_FN_SRL, c_FN_SRA});
            o_read_rt = 1'b1;
            o_dst     = i_instr[15:11];
            w_has_dst = 1'b1;
        end else if (w_op == c_OP_JMP) begin
            o_read_rs = 1'b0;
        end else if (w_op inside {c_OP_SW, c_OP_BEQ, c_OP_BNE}) begin
            o_read_rt = 1'b1;
        end else if ((w_op == c_OP_LW) || is_itype_alu(w_op)) begin
            o_dst     = i_instr[20:16];
            w_has_dst = 1'b1;
        end
    end

    // r0 is hardwired, so writes to it never create a dependency.
    assign o_dst_valid = w_has_dst && (o_dst != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_scoreboard
//  Brief   : Decode-stage hazard unit: in-flight destination pipe, forwarding
//            selects, load-use stall and saturating stall counter.
//  Rev     : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  wire                 clk,
    input  wire                 rst,
    hazard_scoreboard_if.slave  bus
);
    localparam int   ADDR_W   = $clog2(NREG);
    localparam int   SEL_W    = sel_width(DEPTH);
    localparam logic c_NO_FWD = (FWD_EN == 0);

    logic [c_REG_FIELD_W-1:0] w_dec_rs;
    logic [c_REG_FIELD_W-1:0] w_dec_rt;
    logic [c_REG_FIELD_W-1:0] w_dec_dst;
    logic                     w_dec_read_rs;
    logic                     w_dec_read_rt;
    logic                     w_dec_dst_valid;
    logic                     w_dec_load;

    reg_usage_decode u_decode (
        .i_instr     (bus.id_instr),
        .o_rs        (w_dec_rs),
        .o_read_rs   (w_dec_read_rs),
        .o_rt        (w_dec_rt),
        .o_read_rt   (w_dec_read_rt),
        .o_dst       (w_dec_dst),
        .o_dst_valid (w_dec_dst_valid),
        .o_is_load   (w_dec_load)
    );

    logic              r_valid [1:DEPTH];
    logic [ADDR_W-1:0] r_dst   [1:DEPTH];
    logic              r_load  [1:DEPTH];
    logic [CNT_W-1:0]  r_cnt;

    logic              w_rs_rd;
    logic              w_rt_rd;
    logic [SEL_W-1:0]  w_rs_chain [1:DEPTH+1];
    logic [SEL_W-1:0]  w_rt_chain [1:DEPTH+1];
    logic [SEL_W-1:0]  w_rs_sel;
    logic [SEL_W-1:0]  w_rt_sel;
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic              w_rs_ld1;
    logic              w_rt_ld1;
    logic              w_stall;
    logic              w_push;

    assign w_rs_rd = w_dec_read_rs && (w_dec_rs != '0);
    assign w_rt_rd = w_dec_read_rt && (w_dec_rt != '0);

    // Priority chain from the oldest stage down, so the youngest match wins.
    assign w_rs_chain[DEPTH+1] = '0;
    assign w_rt_chain[DEPTH+1] = '0;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_match
        logic w_rs_m;
        logic w_rt_m;
        assign w_rs_m        = r_valid[k] && w_rs_rd && (r_dst[k] == w_dec_rs[ADDR_W-1:0]);
        assign w_rt_m        = r_valid[k] && w_rt_rd && (r_dst[k] == w_dec_rt[ADDR_W-1:0]);
        assign w_rs_chain[k] = w_rs_m ? SEL_W'(k) : w_rs_chain[k+1];
        assign w_rt_chain[k] = w_rt_m ? SEL_W'(k) : w_rt_chain[k+1];
    end

    assign w_rs_sel = w_rs_chain[1];
    assign w_rt_sel = w_rt_chain[1];
    assign w_rs_hit = (w_rs_sel != '0);
    assign w_rt_hit = (w_rt_sel != '0);
    assign w_rs_ld1 = (w_rs_sel == SEL_W'(1)) && r_load[1];
    assign w_rt_ld1 = (w_rt_sel == SEL_W'(1)) && r_load[1];

    assign w_stall = bus.id_valid && !bus.flush &&
                     (w_rs_ld1 || w_rt_ld1 || (c_NO_FWD && (w_rs_hit || w_rt_hit)));
    assign w_push  = bus.id_valid && !w_stall && w_dec_dst_valid;

    assign bus.stall     = w_stall;
    assign bus.fwd_rs    = (w_stall && w_rs_hit && (w_rs_ld1 || c_NO_FWD)) ? '0 : w_rs_sel;
    assign bus.fwd_rt    = (w_stall && w_rt_hit && (w_rt_ld1 || c_NO_FWD)) ? '0 : w_rt_sel;
    assign bus.stall_cnt = r_cnt;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        if (k == 1) begin : g_head
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid[1] <= 1'b0;
                    r_dst[1]   <= '0;
                    r_load[1]  <= 1'b0;
                end else if (bus.flush) begin
                    r_valid[1] <= 1'b0;
                end else if (!bus.hold) begin
                    r_valid[1] <= w_push;
                    r_dst[1]   <= w_dec_dst[ADDR_W-1:0];
                    r_load[1]  <= w_dec_load;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid[k] <= 1'b0;
                    r_dst[k]   <= '0;
                    r_load[k]  <= 1'b0;
                end else if (bus.flush) begin
                    // The flushed stage-1 entry is killed as it advances.
                    r_valid[k] <= (k == 2) ? 1'b0 : r_valid[k-1];
                    r_dst[k]   <= r_dst[k-1];
                    r_load[k]  <= r_load[k-1];
                end else if (!bus.hold) begin
                    r_valid[k] <= r_valid[k-1];
                    r_dst[k]   <= r_dst[k-1];
                    r_load[k]  <= r_load[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_stall && !bus.hold && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : tb_hazard_scoreboard
//  Brief   : Directed-vector scoreboard bench for hazard_scoreboard.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.DEPTH(3), .CNT_W(16)) ifa ();
    hazard_scoreboard_if #(.DEPTH(3), .CNT_W(4))  ifb ();

    hazard_scoreboard #(.NREG(32), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    hazard_scoreboard #(.NREG(32), .DEPTH(3), .FWD_EN(0), .CNT_W(4)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        int          dut;
        string       name;
        logic        st;
        logic [1:0]  fr;
        logic [1:0]  ft;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mcnt [2] = '{0, 0};
    int   cmax [2] = '{65535, 15};

    function automatic logic [31:0] rtype(input int rd, input int rs, input int rt,
                                          input logic [5:0] fn, input int sh);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction
    function automatic logic [31:0] add(input int rd, input int rs, input int rt);
        return rtype(rd, rs, rt, 6'h20, 0);
    endfunction
    function automatic logic [31:0] sub(input int rd, input int rs, input int rt);
        return rtype(rd, rs, rt, 6'h22, 0);
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 16'h0000};
    endfunction
    function automatic logic [31:0] lw(input int rt, input int rs);
        return itype(6'h23, rs, rt);
    endfunction
    function automatic logic [31:0] sw(input int rt, input int rs);
        return itype(6'h2B, rs, rt);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic        st;
        logic [1:0]  fr;
        logic [1:0]  ft;
        logic [15:0] cnt;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.dut == 0) begin
                st = ifa.stall; fr = ifa.fwd_rs; ft = ifa.fwd_rt; cnt = ifa.stall_cnt;
            end else begin
                st = ifb.stall; fr = ifb.fwd_rs; ft = ifb.fwd_rt; cnt = {12'd0, ifb.stall_cnt};
            end
            checks = checks + 1;
            if ({st, fr, ft, cnt} !== {e.st, e.fr, e.ft, e.cnt}) begin
                errors = errors + 1;
                $display("FAIL %s (dut %0d): got stall=%0d fwd_rs=%0d fwd_rt=%0d cnt=%0d, expected stall=%0d fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                         e.name, e.dut, st, fr, ft, cnt, e.st, e.fr, e.ft, e.cnt);
            end
        end
    end

    task automatic drive(input int d, input logic [31:0] ins, input logic v,
                         input logic h, input logic f);
        if (d == 0) begin
            ifa.id_instr = ins; ifa.id_valid = v; ifa.hold = h; ifa.flush = f;
        end else begin
            ifb.id_instr = ins; ifb.id_valid = v; ifb.hold = h; ifb.flush = f;
        end
    endtask

    task automatic expect_now(input int d, input logic est, input logic [1:0] efr,
                              input logic [1:0] eft, input string nm);
        exp_t e;
        e.dut = d; e.name = nm; e.st = est; e.fr = efr; e.ft = eft; e.cnt = 16'(mcnt[d]);
        q.push_back(e);
    endtask

    task automatic step(input int d, input logic [31:0] ins, input logic v, input logic h,
                        input logic f, input logic est, input logic [1:0] efr,
                        input logic [1:0] eft, input string nm);
        drive(d, ins, v, h, f);
        expect_now(d, est, efr, eft, nm);
        @(posedge clk);
        if (est && !h && mcnt[d] < cmax[d]) mcnt[d] = mcnt[d] + 1;
        #1;
    endtask

    task automatic bubbles(input int d, input int n);
        for (int i = 0; i < n; i++) step(d, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, "bubble");
    endtask

    initial begin
        drive(0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        step(0, 32'h0, 0, 0, 0, 0, 0, 0, "reset_a");
        step(1, 32'h0, 0, 0, 0, 0, 0, 0, "reset_b");

        // back-to-back ALU forwarding from stages 1, 2, 3
        step(0, add(3, 1, 2), 1, 0, 0, 0, 0, 0, "alu_producer");
        step(0, sub(5, 3, 4), 1, 0, 0, 0, 1, 0, "fwd_stage1");
        step(0, add(6, 3, 3), 1, 0, 0, 0, 2, 2, "fwd_stage2");
        step(0, add(7, 3, 0), 1, 0, 0, 0, 3, 0, "fwd_stage3");
        bubbles(0, 3);

        // load-use: one stall, then forward from stage 2
        step(0, lw(8, 1),     1, 0, 0, 0, 0, 0, "load");
        step(0, add(9, 8, 8), 1, 0, 0, 1, 0, 0, "load_use_stall");
        step(0, add(9, 8, 8), 1, 0, 0, 0, 2, 2, "load_use_release");
        bubbles(0, 3);

        // shift-immediate reads rt only
        step(0, add(3, 1, 2),                1, 0, 0, 0, 0, 0, "alu_producer2");
        step(0, rtype(4, 3, 3, 6'h00, 2),    1, 0, 0, 0, 0, 1, "sll_rt_only");
        step(0, rtype(10, 4, 2, 6'h02, 1),   1, 0, 0, 0, 0, 0, "srl_rs_ignored");
        bubbles(0, 3);

        // r0 destination is never tracked
        step(0, lw(0, 1),      1, 0, 0, 0, 0, 0, "load_r0");
        step(0, add(11, 0, 0), 1, 0, 0, 0, 0, 0, "read_r0");
        bubbles(0, 3);

        // SW and JMP create no destination
        step(0, add(3, 1, 2),         1, 0, 0, 0, 0, 0, "alu_producer3");
        step(0, sw(3, 1),             1, 0, 0, 0, 0, 1, "sw_reads_rt");
        step(0, {6'h02, 5'd3, 21'd0}, 1, 0, 0, 0, 0, 0, "jmp_reads_none");
        step(0, add(6, 3, 3),         1, 0, 0, 0, 3, 3, "fwd_past_sw_jmp");
        bubbles(0, 3);

        // flush kills the stage-1 load
        step(0, lw(8, 1),      1, 0, 0, 0, 0, 0, "load_then_flush");
        step(0, add(12, 1, 2), 1, 0, 1, 0, 0, 0, "flush_cycle");
        step(0, add(9, 8, 8),  1, 0, 0, 0, 0, 0, "after_flush");
        bubbles(0, 3);

        // hold freezes the pipe
        step(0, add(3, 1, 2), 1, 0, 0, 0, 0, 0, "alu_producer4");
        step(0, lw(8, 1),     1, 1, 0, 0, 0, 0, "hold_1");
        step(0, add(5, 3, 3), 1, 1, 0, 0, 1, 1, "hold_2");
        step(0, add(5, 3, 3), 1, 1, 0, 0, 1, 1, "hold_3");
        step(0, add(5, 3, 3), 1, 0, 0, 0, 1, 1, "hold_release");
        step(0, add(6, 3, 0), 1, 0, 0, 0, 2, 0, "after_hold");
        bubbles(0, 3);

        // stall under hold does not count
        step(0, lw(8, 1),     1, 0, 0, 0, 0, 0, "load2");
        step(0, add(9, 8, 8), 1, 1, 0, 1, 0, 0, "stall_hold_1");
        step(0, add(9, 8, 8), 1, 1, 0, 1, 0, 0, "stall_hold_2");
        step(0, add(9, 8, 8), 1, 0, 0, 1, 0, 0, "stall_counted");
        step(0, add(9, 8, 8), 1, 0, 0, 0, 2, 2, "stall_done");
        drive(0, 32'h0, 1'b0, 1'b0, 1'b0);

        // no forwarding: DEPTH stalls per RAW, counter saturates at 15
        for (int it = 0; it < 6; it++) begin
            step(1, add(3, 1, 2), 1, 0, 0, 0, 0, 0, "nofwd_producer");
            for (int s = 0; s < 3; s++) step(1, add(5, 3, 4), 1, 0, 0, 1, 0, 0, "nofwd_stall");
            step(1, add(5, 3, 4), 1, 0, 0, 0, 0, 0, "nofwd_release");
        end
        drive(1, 32'h0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset clears pipe and counter before any edge
        step(0, add(3, 1, 2), 1, 0, 0, 0, 0, 0, "pre_reset");
        drive(0, add(5, 3, 4), 1'b1, 1'b0, 1'b0);
        rst     = 1'b1;
        mcnt[0] = 0;
        expect_now(0, 1'b0, 2'd0, 2'd0, "async_reset");
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);

        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
